// File: rtl/morningjava_sqrt_iter_pkg.sv
// Shared types and elaboration-time helpers for the iterative square-root block.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } sqrt_state_t;

  function automatic bit sqrt_params_ok(input int width, input int unroll);
    if ((width < 4) || ((width % 2) != 0) || (unroll < 1)) begin
      return 1'b0;
    end else begin
      return (((width / 2) % unroll) == 0);
    end
  endfunction

  // Falls back to 1 on bad parameters so the design still elaborates far enough to report them.
  function automatic int sqrt_iter_count(input int width, input int unroll);
    if (!sqrt_params_ok(width, unroll)) begin
      return 1;
    end else begin
      return width / 2 / unroll;
    end
  endfunction

  function automatic int sqrt_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/morningjava_sqrt_iter_step.sv
// One combinational non-restoring (Li/Chu) square-root step: consumes two operand bits, yields one root bit.
module morningjava_sqrt_step
  import sqrt_pkg::*;
#(
  parameter int G_WIDTH = 8
) (
  input  logic [G_WIDTH/2+1:0] r_in,
  input  logic [G_WIDTH/2-1:0] q_in,
  input  logic [1:0]           d_in,
  output logic [G_WIDTH/2+1:0] r_out,
  output logic [G_WIDTH/2-1:0] q_out
);
  localparam int H = G_WIDTH / 2;

  logic [H+1:0] x_s;
  logic [H+1:0] y_s;
  logic [H+1:0] r_nxt_s;

  // Negative partial remainder restores by adding 4q+3, otherwise subtracts 4q+1.
  always_comb begin
    x_s = (r_in << 2) + {{H{1'b0}}, d_in};
    y_s = {q_in, r_in[H+1], 1'b1};
    if (r_in[H+1]) begin
      r_nxt_s = x_s + y_s;
    end else begin
      r_nxt_s = x_s - y_s;
    end
    r_out = r_nxt_s;
    q_out = {q_in[H-2:0], ~r_nxt_s[H+1]};
  end

endmodule

// File: rtl/morningjava_sqrt_iter.sv
// Handshaked iterative integer square root with remainder, G_UNROLL root bits per clock.
// Optional macro SQRT_ROUND_EN: data_out becomes the round-to-nearest root (saturating).
module morningjava_sqrt_iter
  import sqrt_pkg::*;
#(
  parameter int G_WIDTH  = 8,
  parameter int G_UNROLL = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [G_WIDTH-1:0]   data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [G_WIDTH/2-1:0] data_out,
  output logic [G_WIDTH/2:0]   rem_out
);
  localparam int H  = G_WIDTH / 2;
  localparam int N  = sqrt_iter_count(G_WIDTH, G_UNROLL);
  localparam int CW = sqrt_cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (!sqrt_params_ok(G_WIDTH, G_UNROLL)) begin : g_param_err
    $error("morningjava_sqrt_iter: G_WIDTH must be even and >= 4, G_UNROLL must divide G_WIDTH/2");
  end

  sqrt_state_t         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [G_WIDTH-1:0]  opnd_q, opnd_d;
  logic [H+1:0]        r_q, r_d;
  logic [H-1:0]        q_q, q_d;
  logic [H-1:0]        data_out_q, data_out_d;
  logic [H:0]          rem_q, rem_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [G_UNROLL:0][H+1:0] r_chain;
  logic [G_UNROLL:0][H-1:0] q_chain;
  logic [H:0]          rem_fix_s;
  logic [H-1:0]        root_s;

  assign r_chain[0] = r_q;
  assign q_chain[0] = q_q;

  for (genvar k = 0; k < G_UNROLL; k++) begin : g_step
    morningjava_sqrt_step #(.G_WIDTH(G_WIDTH)) u_step (
      .r_in  (r_chain[k]),
      .q_in  (q_chain[k]),
      .d_in  (opnd_q[G_WIDTH-1-2*k -: 2]),
      .r_out (r_chain[k+1]),
      .q_out (q_chain[k+1])
    );
  end

`ifdef SQRT_ROUND_EN
  localparam logic [H-1:0] ROOT_MAX = {H{1'b1}};
  localparam logic [H-1:0] ROOT_ONE = H'(1);
`endif

  // Final remainder correction; the sum is non-negative so H+1 bits hold it exactly.
  always_comb begin
    if (r_q[H+1]) begin
      rem_fix_s = r_q[H:0] + {q_q, 1'b1};
    end else begin
      rem_fix_s = r_q[H:0];
    end
`ifdef SQRT_ROUND_EN
    if ((rem_fix_s > {1'b0, q_q}) && (q_q != ROOT_MAX)) begin
      root_s = q_q + ROOT_ONE;
    end else begin
      root_s = q_q;
    end
`else
    root_s = q_q;
`endif
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    r_d        = r_q;
    q_d        = q_q;
    data_out_d = data_out_q;
    rem_d      = rem_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = BUSY;
          opnd_d  = data_in;
          r_d     = '0;
          q_d     = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        r_d    = r_chain[G_UNROLL];
        q_d    = q_chain[G_UNROLL];
        opnd_d = opnd_q << (2 * G_UNROLL);
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      FIX: begin
        data_out_d = root_s;
        rem_d      = rem_fix_s;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  // State and output registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      opnd_q      <= '0;
      r_q         <= '0;
      q_q         <= '0;
      data_out_q  <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opnd_q      <= opnd_d;
      r_q         <= r_d;
      q_q         <= q_d;
      data_out_q  <= data_out_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign rem_out   = rem_q;

endmodule
